// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: sweeps detector codes 0..15 for DWELL cycles each, collecting a result mask and hit count.
// Define PRIME_SCAN_DEBOUNCE_EN to synchronize and debounce a raw push-button start.
module prime_scan_ctrl #(
  parameter int DWELL = 1,
  parameter int DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic [3:0]  sel,
  output logic        det_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] mask,
  output logic [4:0]  count
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] dw;
  logic req, smp, last;
  if (DWELL < 1 || DWELL > 255 || DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_param
    $error("prime_scan_ctrl: DWELL and DB_CYCLES must be in 1..255");
  end
`ifdef PRIME_SCAN_DEBOUNCE_EN
  logic s1, s2, db, flip;
  logic [7:0] db_cnt;
  // The request fires on the same edge the debounced level rises.
  assign flip = (s2 != db) && db_cnt == 8'(DB_CYCLES - 1);
  assign req = flip && s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= start;
      s2 <= s1;
      db <= flip ? s2 : db;
      db_cnt <= (s2 == db || flip) ? '0 : db_cnt + 1'b1;
    end
`else
  assign req = start;
`endif
  assign smp = dw == 8'(DWELL - 1);
  assign last = smp && sel == 4'hF;
  always_comb begin
    state_n = state == DRIVE ? (last ? DONE : DRIVE) : (req ? DRIVE : state);
    busy = state == DRIVE;
    det_en = state == DRIVE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= '0;
      dw <= '0;
      mask <= '0;
      count <= '0;
    end else if (state != DRIVE && req) begin
      sel <= '0;
      dw <= '0;
      mask <= '0;
      count <= '0;
    end else if (state == DRIVE) begin
      dw <= smp ? '0 : dw + 1'b1;
      if (smp) begin
        mask[sel] <= f_in;
        count <= count + 5'(f_in);
        sel <= last ? sel : sel + 1'b1;
      end
    end
endmodule

// File: tb/tb_prime_scan_ctrl.sv
// tb_prime_scan_ctrl: randomized and directed checks of two sweep controllers (DWELL 1 and 3) against a cycle model.
module tb_prime_scan_ctrl;
  localparam int DB = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic f_in [2];
  logic [3:0] sel [2];
  logic det_en [2], busy [2], done [2];
  logic [15:0] mask [2];
  logic [4:0] count [2];
  int fm [2];
  int checks = 0, fails = 0;
  int ph [2], t [2];
  logic [15:0] m [2];
  int nsw = 0;
  logic pb = 1'b0;
  always #5 clk = ~clk;

  prime_scan_ctrl #(.DWELL(1), .DB_CYCLES(DB)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in[0]),
    .sel(sel[0]), .det_en(det_en[0]), .busy(busy[0]), .done(done[0]), .mask(mask[0]), .count(count[0]));
  prime_scan_ctrl #(.DWELL(3), .DB_CYCLES(DB)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in[1]),
    .sel(sel[1]), .det_en(det_en[1]), .busy(busy[1]), .done(done[1]), .mask(mask[1]), .count(count[1]));

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int dwof(int i);
    return i == 0 ? 1 : 3;
  endfunction

  // Ideal detector: 0 when disabled; fm selects tied-0, tied-1 or prime behaviour.
  always_comb
    for (int i = 0; i < 2; i++)
      f_in[i] = fm[i] == 2 ? (det_en[i] && is_prime(int'(sel[i]))) : (fm[i] == 1);

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: sweep position is just elapsed cycles since acceptance.
  logic [31:0] h = '0;
  logic lvl = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0;
        t[i] = 0;
        m[i] = '0;
      end
      h = '0;
      lvl = 1'b0;
    end else begin
      bit req_m;
`ifdef PRIME_SCAN_DEBOUNCE_EN
      bit all1, all0;
      all1 = ((h >> 1) & ((32'd1 << DB) - 1)) == ((32'd1 << DB) - 1);
      all0 = ((h >> 1) & ((32'd1 << DB) - 1)) == 0;
      req_m = all1 && !lvl;
      lvl = all1 ? 1'b1 : all0 ? 1'b0 : lvl;
      h = {h[30:0], start};
`else
      req_m = start;
`endif
      for (int i = 0; i < 2; i++) begin
        if (ph[i] == 1) begin
          int k;
          k = t[i] / dwof(i);
          if (t[i] % dwof(i) == dwof(i) - 1) m[i][k] = fm[i] == 2 ? is_prime(k) : (fm[i] == 1);
          t[i]++;
          if (t[i] == 16 * dwof(i)) ph[i] = 2;
        end else if (req_m) begin
          ph[i] = 1;
          t[i] = 0;
          m[i] = '0;
        end
      end
    end

  always @(negedge clk) begin
    if (rst_n)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(ph[i] == 1));
        chk($sformatf("u%0d.det_en", i), int'(det_en[i]), int'(ph[i] == 1));
        chk($sformatf("u%0d.done", i), int'(done[i]), int'(ph[i] == 2));
        chk($sformatf("u%0d.sel", i), int'(sel[i]), ph[i] == 1 ? t[i] / dwof(i) : ph[i] == 2 ? 15 : 0);
        chk($sformatf("u%0d.mask", i), int'(mask[i]), int'(m[i]));
        chk($sformatf("u%0d.count", i), int'(count[i]), $countones(m[i]));
      end
    if (busy[0] && !pb) nsw++;
    pb = busy[0];
  end

  task automatic pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic zero_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d sel", tag, i), int'(sel[i]), 0);
      chk($sformatf("%s u%0d det_en", tag, i), int'(det_en[i]), 0);
      chk($sformatf("%s u%0d busy", tag, i), int'(busy[i]), 0);
      chk($sformatf("%s u%0d done", tag, i), int'(done[i]), 0);
      chk($sformatf("%s u%0d mask", tag, i), int'(mask[i]), 0);
      chk($sformatf("%s u%0d count", tag, i), int'(count[i]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fm[0] = 2;
    fm[1] = 1;
    repeat (3) @(negedge clk);
    zero_check("reset");
    rst_n = 1'b1;
    @(negedge clk);
`ifdef PRIME_SCAN_DEBOUNCE_EN
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch sweeps", nsw, 0);
    start = 1'b1;
    begin
      int n;
      n = 0;
      for (int k = 1; k <= 20 && n == 0; k++) begin
        @(negedge clk);
        if (busy[0]) n = k;
      end
      chk("busy latency", n, 6);
    end
    repeat (94) @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    chk("hold sweeps", nsw, 1);
    chk("hold mask", int'(mask[0]), 'h28AC);
`else
    pulse();
    repeat (4) @(negedge clk);
    pulse();
    repeat (10) @(negedge clk);
    chk("u1 done early", int'(done[0]), 0);
    @(negedge clk);
    chk("u1 done", int'(done[0]), 1);
    chk("u1 mask", int'(mask[0]), 'h28AC);
    chk("u1 count", int'(count[0]), 6);
    chk("u1 sel", int'(sel[0]), 15);
    chk("u1 det_en", int'(det_en[0]), 0);
    repeat (31) @(negedge clk);
    chk("u3 done early", int'(done[1]), 0);
    @(negedge clk);
    chk("u3 done", int'(done[1]), 1);
    chk("u3 mask", int'(mask[1]), 'hFFFF);
    chk("u3 count", int'(count[1]), 16);
    chk("one sweep u1", nsw, 1);
    fm[0] = 0;
    fm[1] = 0;
    pulse();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("restart u%0d mask", i), int'(mask[i]), 0);
      chk($sformatf("restart u%0d busy", i), int'(busy[i]), 1);
    end
    repeat (50) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("zero u%0d done", i), int'(done[i]), 1);
      chk($sformatf("zero u%0d mask", i), int'(mask[i]), 0);
      chk($sformatf("zero u%0d count", i), int'(count[i]), 0);
    end
    fm[0] = 2;
    fm[1] = 2;
    pulse();
    repeat (9) @(negedge clk);
    chk("u1 sel before reset", int'(sel[0]), 9);
    #2 rst_n = 1'b0;
    #1 zero_check("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse();
    repeat (49) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fresh u%0d done", i), int'(done[i]), 1);
      chk($sformatf("fresh u%0d mask", i), int'(mask[i]), 'h28AC);
      chk($sformatf("fresh u%0d count", i), int'(count[i]), 6);
    end
`endif
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      start = $urandom_range(0, 9) == 0;
      if (ph[0] != 1 && ph[1] != 1 && $urandom_range(0, 3) == 0) begin
        fm[0] = $urandom_range(0, 2);
        fm[1] = $urandom_range(0, 2);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
